mealy_pattern_bank: RTL and testbench
=====================================

# mealy_pattern_bank

Parametrised Mealy-type serial pattern detector. It compares a 1-bit input stream against up to NUM_PAT runtime-programmable patterns of PAT_LEN bits each. Match flags are asserted in the same cycle as the completing bit, and a saturating hit counter is kept per pattern. It generalises the fixed two-pattern, 3-bit detector with pattern length, pattern count, runtime pattern loading, per-pattern enable, input qualification and overlap/non-overlap mode.

## Interface
Parameters:
- PAT_LEN, default 3: pattern length in bits; legal range 2..16.
- NUM_PAT, default 2: number of pattern slots; legal range 1..8.
- CNT_W, default 8: width of each hit counter.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- i  in  1  serial data bit.
- valid  in  1  i is meaningful this cycle; when low, the input is ignored and no state advances.
- overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping matches per pattern.
- cfg_we  in  1  pattern write strobe.
- cfg_idx  in  max(1,$clog2(NUM_PAT))  slot written; writes to indices ≥ NUM_PAT are ignored.
- cfg_pattern  in  PAT_LEN  new pattern; MSB is the oldest bit, LSB is the completing bit.
- cfg_enable  in  1  enable bit written together with the pattern.
- clear_counts  in  1  synchronous clear of all hit counters.
- o  out  NUM_PAT  combinational match flags, bit k for slot k.
- hit_count  out  NUM_PAT*CNT_W  counter k occupies bits [k*CNT_W +: CNT_W].

## Operation
- History register hist[PAT_LEN-2:0]:
  - On each valid cycle it shifts left with i entering at the LSB.
  - Reset value is 0.
- Per-slot state:
  - pat[k], PAT_LEN bits.
  - en[k], 1 bit.
  - fill[k], a counter saturating at PAT_LEN-1 that holds the number of history bits usable by slot k.
- Reset values:
  - pat[0] is all ones and en[0]=1.
  - pat[1] is 1 (i.e. 0…01) and en[1]=1.
  - All other slots: pat=0, en=0.
  - All fill=0 and all counters=0.
- Match condition: o[k] = valid & en[k] & (fill[k] == PAT_LEN-1) & ({hist, i} == pat[k]).
- fill[k] update on a valid cycle:
  - If overlap=0 and o[k]=1, fill[k] goes to 0.
  - Otherwise fill[k] increments, saturating at PAT_LEN-1.
- Counters:
  - When o[k]=1, hit_count[k] increments, saturating at 2^CNT_W-1 with no wrap.
  - clear_counts has priority over an increment in the same cycle.
- Config write (cfg_we=1, legal idx):
  - pat[idx] and en[idx] load at the edge, and fill[idx] goes to 0.
  - The cycle of the write still compares against the old pattern, so o and counters may reflect the old pattern for that one cycle.
  - The counter is not cleared by a write.
- valid=0: hist, fill and counters hold, and o is all zeros. Config writes and clear_counts still take effect.
- overlap may change at any cycle. It affects only the fill update of that cycle.

## Timing
- o is purely combinational from i, valid and registered state, with zero latency: it is high during the cycle the completing bit is presented.
- hit_count reflects a match on the following cycle.
- After reset deassertion, at least PAT_LEN-1 valid bits are needed before any o can assert. With PAT_LEN=3, the earliest match is on the 3rd valid bit.
- Asserting reset_n low mid-stream:
  - hist, fill, counters and patterns return to their reset values immediately.
  - o goes to 0 immediately, because fill=0.
- Simultaneous events on the same slot:
  - A match and a config write in the same cycle give: counter increments, fill=0, new pattern loaded.
  - A match and clear_counts in the same cycle leave the counter at 0.

## Test plan
- Stream 1,1,1,0,0,1,1,0,0,1, one bit per cycle, valid=1, overlap=1, defaults PAT_LEN=3, NUM_PAT=2:
  - o[0] is high only on bit index 2.
  - o[1] is high only on indices 5 and 9.
  - Final hit_count: slot0=1, slot1=2.
- Stream of six 1s:
  - overlap=1: o[0] is high on indices 2,3,4,5 and the count ends at 4.
  - overlap=0: o[0] is high on indices 2 and 5 only, and the count ends at 2.
- Gaps in the stream: stream 1,1,1 with valid=0 for 3 cycles between each bit (i toggling randomly while valid=0):
  - o[0] asserts only on the third valid bit.
  - o is 0 throughout all invalid cycles.
- Runtime reprogramming: write slot 1 to 110 with enable=1, then stream 0,1,1,0:
  - o[1] is high on index 3.
  - Writing with enable=0 and replaying the stream gives no o[1].
  - hit_count[1] is not cleared by the writes.
- Counter saturation: CNT_W=2 with 5 matches on slot 0:
  - Count sequence is 1,2,3,3,3.
  - clear_counts asserted in a match cycle leaves the count at 0 on the next cycle.
- Reset mid-stream: pull reset_n low asynchronously after 1,1:
  - All outputs are 0 without a clock edge.
  - After release, the stream 1,1,1 matches only on its third bit, with no carry-over from before the reset.

Source files
------------

// File: rtl/mealy_pattern_bank_if.sv
// Bus bundle for mealy_pattern_bank: serial input stream, pattern
// configuration port, combinational match flags and packed hit counters.
interface mealy_pattern_bank_if #(
    parameter int unsigned PAT_LEN = 3,
    parameter int unsigned NUM_PAT = 2,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

    logic                       i;
    logic                       valid;
    logic                       overlap;
    logic                       cfg_we;
    logic [IDX_W-1:0]           cfg_idx;
    logic [PAT_LEN-1:0]         cfg_pattern;
    logic                       cfg_enable;
    logic                       clear_counts;
    logic [NUM_PAT-1:0]         o;
    logic [NUM_PAT*CNT_W-1:0]   hit_count;

    modport master (
        output i, valid, overlap, cfg_we, cfg_idx, cfg_pattern, cfg_enable, clear_counts,
        input  o, hit_count
    );

    modport slave (
        input  i, valid, overlap, cfg_we, cfg_idx, cfg_pattern, cfg_enable, clear_counts,
        output o, hit_count
    );
endinterface

// File: rtl/mealy_pattern_bank.sv
// Mealy serial pattern detector with NUM_PAT runtime-programmable slots.
// Match flags are combinational on the completing bit; each slot keeps a
// saturating hit counter and a fill counter that gates matches until enough
// history has been seen (and restarts after a non-overlapping match).
module mealy_pattern_bank #(
    parameter int unsigned PAT_LEN = 3,
    parameter int unsigned NUM_PAT = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    mealy_pattern_bank_if.slave  bus
);
    localparam int unsigned HIST_W = PAT_LEN - 1;
    localparam int unsigned FILL_W = $clog2(PAT_LEN);
    localparam int unsigned IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    logic [HIST_W-1:0]  hist_q, hist_d;
    logic [PAT_LEN-1:0] pat_q  [NUM_PAT];
    logic [PAT_LEN-1:0] pat_d  [NUM_PAT];
    logic               en_q   [NUM_PAT];
    logic               en_d   [NUM_PAT];
    logic [FILL_W-1:0]  fill_q [NUM_PAT];
    logic [FILL_W-1:0]  fill_d [NUM_PAT];
    logic [CNT_W-1:0]   cnt_q  [NUM_PAT];
    logic [CNT_W-1:0]   cnt_d  [NUM_PAT];

    logic [PAT_LEN-1:0] window;
    logic [NUM_PAT-1:0] match;

    // Match detection: current bit appended to history, compared per slot.
    always_comb begin
        window = {hist_q, bus.i};
        match  = '0;
        for (int unsigned k = 0; k < NUM_PAT; k++) begin
            match[k] = bus.valid & en_q[k] & (fill_q[k] == FILL_MAX) & (window == pat_q[k]);
        end
    end

    // Outputs: match flags and packed counter view.
    always_comb begin
        bus.o         = match;
        bus.hit_count = '0;
        for (int unsigned k = 0; k < NUM_PAT; k++) begin
            bus.hit_count[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    // Next-state: history shift, fill tracking, counters and config loads.
    always_comb begin
        hist_d = bus.valid ? window[HIST_W-1:0] : hist_q;
        for (int unsigned k = 0; k < NUM_PAT; k++) begin
            pat_d[k]  = pat_q[k];
            en_d[k]   = en_q[k];
            fill_d[k] = fill_q[k];
            cnt_d[k]  = cnt_q[k];

            if (bus.valid) begin
                if (!bus.overlap && match[k]) begin
                    fill_d[k] = '0;
                end else if (fill_q[k] != FILL_MAX) begin
                    fill_d[k] = fill_q[k] + FILL_W'(1);
                end
            end

            if (bus.clear_counts) begin
                cnt_d[k] = '0;
            end else if (match[k] && (cnt_q[k] != '1)) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end

            // Indices beyond the last slot never compare equal, so such writes drop out.
            if (bus.cfg_we && (bus.cfg_idx == IDX_W'(k))) begin
                pat_d[k]  = bus.cfg_pattern;
                en_d[k]   = bus.cfg_enable;
                fill_d[k] = '0;
            end
        end
    end

    // State registers with asynchronous active-low reset to default patterns.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            for (int unsigned k = 0; k < NUM_PAT; k++) begin
                if (k == 0) begin
                    pat_q[k] <= '1;
                    en_q[k]  <= 1'b1;
                end else if (k == 1) begin
                    pat_q[k] <= PAT_LEN'(1);
                    en_q[k]  <= 1'b1;
                end else begin
                    pat_q[k] <= '0;
                    en_q[k]  <= 1'b0;
                end
                fill_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            hist_q <= hist_d;
            for (int unsigned k = 0; k < NUM_PAT; k++) begin
                pat_q[k]  <= pat_d[k];
                en_q[k]   <= en_d[k];
                fill_q[k] <= fill_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end
endmodule

// File: tb/tb_mealy_pattern_bank.sv
// Directed testbench for mealy_pattern_bank (PAT_LEN=3, NUM_PAT=2).
// A second instance with CNT_W=2 shares the same stimulus for saturation.
module tb_mealy_pattern_bank;
    logic clock;
    logic reset_n;

    mealy_pattern_bank_if #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(8)) ifm ();
    mealy_pattern_bank_if #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(2)) ifs ();

    mealy_pattern_bank #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifm.slave)
    );

    mealy_pattern_bank #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(2)) dut_sat (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifs.slave)
    );

    assign ifs.i            = ifm.i;
    assign ifs.valid        = ifm.valid;
    assign ifs.overlap      = ifm.overlap;
    assign ifs.cfg_we       = ifm.cfg_we;
    assign ifs.cfg_idx      = ifm.cfg_idx;
    assign ifs.cfg_pattern  = ifm.cfg_pattern;
    assign ifs.cfg_enable   = ifm.cfg_enable;
    assign ifs.clear_counts = ifm.clear_counts;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    logic [1:0]  o_s;

    // Present one bit, sample o mid-cycle, then advance past the next edge.
    task automatic step(input logic b, input logic v);
        ifm.i     = b;
        ifm.valid = v;
        @(negedge clock);
        o_s = ifm.o;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ifm.i = 1'b0; ifm.valid = 1'b0; ifm.overlap = 1'b1;
        ifm.cfg_we = 1'b0; ifm.cfg_idx = '0; ifm.cfg_pattern = '0;
        ifm.cfg_enable = 1'b0; ifm.clear_counts = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (ifm.o !== 2'b00) $display("FAIL reset_o actual=%b required=00", ifm.o);
        else pass_cnt++;
        total_cnt++;
        if (ifm.hit_count !== 16'h0000) $display("FAIL reset_count actual=%h required=0000", ifm.hit_count);
        else pass_cnt++;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(1'b1, 1'b1);
        total_cnt++;
        if (o_s !== 2'b00) $display("FAIL reset_first_bit actual=%b required=00", o_s);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic stream [10] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 1};
        logic e0, e1;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            step(stream[n], 1'b1);
            e0 = (n == 2);
            e1 = (n == 5) || (n == 9);
            total_cnt++;
            if (o_s !== {e1, e0}) $display("FAIL basic_o idx=%0d actual=%b required=%b", n, o_s, {e1, e0});
            else pass_cnt++;
        end
        total_cnt++;
        if (ifm.hit_count !== 16'h0201) $display("FAIL basic_counts actual=%h required=0201", ifm.hit_count);
        else pass_cnt++;
    endtask

    task automatic test_overlap();
        logic e0;
        for (int m = 0; m < 2; m++) begin
            do_reset();
            ifm.overlap = (m == 0);
            for (int n = 0; n < 6; n++) begin
                step(1'b1, 1'b1);
                e0 = (m == 0) ? (n >= 2) : (n == 2 || n == 5);
                total_cnt++;
                if (o_s !== {1'b0, e0}) $display("FAIL overlap%0d_o idx=%0d actual=%b required=%b", 1 - m, n, o_s, {1'b0, e0});
                else pass_cnt++;
            end
            total_cnt++;
            if (ifm.hit_count[7:0] !== ((m == 0) ? 8'd4 : 8'd2))
                $display("FAIL overlap%0d_count actual=%0d required=%0d", 1 - m, ifm.hit_count[7:0], (m == 0) ? 4 : 2);
            else pass_cnt++;
        end
        ifm.overlap = 1'b1;
    endtask

    task automatic test_gaps();
        do_reset();
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 1'b1);
            total_cnt++;
            if (o_s !== {1'b0, n == 2}) $display("FAIL gaps_valid idx=%0d actual=%b required=%b", n, o_s, {1'b0, n == 2});
            else pass_cnt++;
            for (int g = 0; g < 3; g++) begin
                step(1'($urandom_range(0, 1)), 1'b0);
                total_cnt++;
                if (o_s !== 2'b00) $display("FAIL gaps_invalid idx=%0d gap=%0d actual=%b required=00", n, g, o_s);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (ifm.hit_count !== 16'h0001) $display("FAIL gaps_count actual=%h required=0001", ifm.hit_count);
        else pass_cnt++;
    endtask

    task automatic test_reprogram();
        logic stream [4] = '{0, 1, 1, 0};
        do_reset();
        for (int r = 0; r < 2; r++) begin
            ifm.cfg_we = 1'b1; ifm.cfg_idx = 1'b1; ifm.cfg_pattern = 3'b110; ifm.cfg_enable = (r == 0);
            step(1'b0, 1'b0);
            ifm.cfg_we = 1'b0;
            for (int n = 0; n < 4; n++) begin
                step(stream[n], 1'b1);
                total_cnt++;
                if (o_s !== {(r == 0) && (n == 3), 1'b0})
                    $display("FAIL reprog%0d_o idx=%0d actual=%b required=%b", r, n, o_s, {(r == 0) && (n == 3), 1'b0});
                else pass_cnt++;
            end
            total_cnt++;
            if (ifm.hit_count[15:8] !== 8'd1) $display("FAIL reprog%0d_count actual=%0d required=1", r, ifm.hit_count[15:8]);
            else pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int n = 0; n < 5; n++) begin
            step(1'b1, 1'b1);
            total_cnt++;
            if (ifs.hit_count[1:0] !== exp_cnt[n]) $display("FAIL sat_count match=%0d actual=%0d required=%0d", n, ifs.hit_count[1:0], exp_cnt[n]);
            else pass_cnt++;
        end
        ifm.clear_counts = 1'b1;
        step(1'b1, 1'b1);
        ifm.clear_counts = 1'b0;
        total_cnt++;
        if (o_s[0] !== 1'b1) $display("FAIL sat_clear_match actual=%b required=1", o_s[0]);
        else pass_cnt++;
        total_cnt++;
        if (ifs.hit_count !== 4'h0 || ifm.hit_count !== 16'h0000)
            $display("FAIL sat_clear_count actual=%h/%h required=0/0000", ifs.hit_count, ifm.hit_count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        ifm.cfg_we = 1'b1; ifm.cfg_idx = 1'b0; ifm.cfg_pattern = 3'b010; ifm.cfg_enable = 1'b1;
        step(1'b1, 1'b1);
        ifm.cfg_we = 1'b0;
        total_cnt++;
        if (o_s[0] !== 1'b1) $display("FAIL b2b_old_pattern actual=%b required=1", o_s[0]);
        else pass_cnt++;
        total_cnt++;
        if (ifm.hit_count[7:0] !== 8'd1) $display("FAIL b2b_count1 actual=%0d required=1", ifm.hit_count[7:0]);
        else pass_cnt++;
        step(1'b0, 1'b1);
        total_cnt++;
        if (o_s[0] !== 1'b0) $display("FAIL b2b_fill0 actual=%b required=0", o_s[0]);
        else pass_cnt++;
        step(1'b1, 1'b1);
        total_cnt++;
        if (o_s[0] !== 1'b0) $display("FAIL b2b_fill1 actual=%b required=0", o_s[0]);
        else pass_cnt++;
        step(1'b0, 1'b1);
        total_cnt++;
        if (o_s[0] !== 1'b1) $display("FAIL b2b_new_pattern actual=%b required=1", o_s[0]);
        else pass_cnt++;
        total_cnt++;
        if (ifm.hit_count[7:0] !== 8'd2) $display("FAIL b2b_count2 actual=%0d required=2", ifm.hit_count[7:0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int n = 0; n < 5; n++) step(1'b1, 1'b1);
        ifm.i = 1'b1;
        ifm.valid = 1'b1;
        #1;
        total_cnt++;
        if (ifm.o[0] !== 1'b1 || ifm.hit_count[7:0] !== 8'd3)
            $display("FAIL midrst_before actual=%b/%0d required=1/3", ifm.o[0], ifm.hit_count[7:0]);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (ifm.o !== 2'b00 || ifm.hit_count !== 16'h0000)
            $display("FAIL midrst_async actual=%b/%h required=00/0000", ifm.o, ifm.hit_count);
        else pass_cnt++;
        ifm.valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 1'b1);
            total_cnt++;
            if (o_s !== {1'b0, n == 2}) $display("FAIL midrst_after idx=%0d actual=%b required=%b", n, o_s, {1'b0, n == 2});
            else pass_cnt++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_gaps();
        test_reprogram();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
